// File: rtl/xor_cipher_pkg.sv
// Shared constants and types for the XOR cipher datapath.
// Used by the assembler, the encryptor and the serializer.
package xor_cipher_pkg;

    localparam int MSG_SIZE_D = 512;
    localparam int OUT_W_D    = 8;
    localparam int NCHUNK_D   = MSG_SIZE_D / OUT_W_D;

    // Counter width for n chunks; at least one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_D = cntWidth(NCHUNK_D);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } serState_t;

endpackage

// File: rtl/cipher_shift_reg.sv
// Parallel-load register that shifts right by OUT_W bits.
// Ports: iClk, iRst (async low), iLoad, iShift, iData, oChunk (low OUT_W bits).
module cipher_shift_reg #(
    parameter int MSG_SIZE = 512,
    parameter int OUT_W    = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iLoad,
    input  logic                iShift,
    input  logic [MSG_SIZE-1:0] iData,
    output logic [OUT_W-1:0]    oChunk
);

    logic [MSG_SIZE-1:0] q;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            q <= '0;
        end else if (iLoad) begin
            q <= iData;
        end else if (iShift) begin
            q <= q >> OUT_W;
        end
    end

    assign oChunk = q[OUT_W-1:0];

endmodule

// File: rtl/cipher_serializer.sv
// Captures ciphertext on the encryptor's done edge and streams it out
// OUT_W bits per valid/ready handshake, least significant chunk first.
// Ports: iClk, iRst (async low), iEncrypt_done, iCiphertext, iReady,
//        oData, oValid, oLast, oBusy, oSent_done (sticky until reset).
module cipher_serializer
    import xor_cipher_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_D,
    parameter int OUT_W    = OUT_W_D
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEncrypt_done,
    input  logic [MSG_SIZE-1:0] iCiphertext,
    input  logic                iReady,
    output logic [OUT_W-1:0]    oData,
    output logic                oValid,
    output logic                oLast,
    output logic                oBusy,
    output logic                oSent_done
);

    localparam int NCHUNK = MSG_SIZE / OUT_W;
    localparam int CNT_W  = cntWidth(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

    serState_t        state;
    serState_t        nextState;
    logic             doneD;
    logic [CNT_W-1:0] cnt;
    logic             start;
    logic             load;
    logic             hs;
    logic             atLast;
    logic [OUT_W-1:0] chunk;

    // A done level already high at reset release counts as an edge.
    assign start  = iEncrypt_done & ~doneD;
    assign hs     = (state == SEND) & iReady;
    assign atLast = (cnt == LAST_IDX);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= IDLE;
            doneD <= 1'b0;
        end else begin
            state <= nextState;
            doneD <= iEncrypt_done;
        end
    end

    always_comb begin
        nextState = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = SEND;
                    load      = 1'b1;
                end
            end
            SEND: begin
                if (hs && atLast) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = DONE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Final handshake leaves the counter parked; DONE follows, so no wrap.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (hs && !atLast) begin
            cnt <= cnt + 1'b1;
        end
    end

    cipher_shift_reg #(
        .MSG_SIZE (MSG_SIZE),
        .OUT_W    (OUT_W)
    ) uShift (
        .iClk   (iClk),
        .iRst   (iRst),
        .iLoad  (load),
        .iShift (hs),
        .iData  (iCiphertext),
        .oChunk (chunk)
    );

    assign oValid     = (state == SEND);
    assign oBusy      = oValid;
    assign oLast      = oValid & atLast;
    assign oData      = oValid ? chunk : '0;
    assign oSent_done = (state == DONE);

endmodule

// File: tb/tb_cipher_serializer.sv
// Self-checking bench for cipher_serializer: full-size and 16/8 instances.
// Expected chunks come from a byte-array model of the message.
module tb_cipher_serializer;

    localparam int MSG    = 512;
    localparam int W      = 8;
    localparam int NCHUNK = MSG / W;

    logic           iClk = 1'b0;
    logic           iRst = 1'b0;
    logic           iEncrypt_done = 1'b0;
    logic [MSG-1:0] iCiphertext = '0;
    logic           iReady = 1'b0;
    logic [W-1:0]   oData;
    logic           oValid;
    logic           oLast;
    logic           oBusy;
    logic           oSent_done;

    logic           rDone = 1'b0;
    logic [15:0]    rCt = '0;
    logic           rReady = 1'b0;
    logic [7:0]     rData;
    logic           rValid;
    logic           rLast;
    logic           rBusy;
    logic           rSent;

    int checks = 0;
    int errors = 0;

    logic [7:0] msgBytes [NCHUNK];

    always #5 iClk = ~iClk;

    cipher_serializer #(.MSG_SIZE(MSG), .OUT_W(W)) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iEncrypt_done (iEncrypt_done),
        .iCiphertext   (iCiphertext),
        .iReady        (iReady),
        .oData         (oData),
        .oValid        (oValid),
        .oLast         (oLast),
        .oBusy         (oBusy),
        .oSent_done    (oSent_done)
    );

    cipher_serializer #(.MSG_SIZE(16), .OUT_W(8)) dutSmall (
        .iClk          (iClk),
        .iRst          (iRst),
        .iEncrypt_done (rDone),
        .iCiphertext   (rCt),
        .iReady        (rReady),
        .oData         (rData),
        .oValid        (rValid),
        .oLast         (rLast),
        .oBusy         (rBusy),
        .oSent_done    (rSent)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MSG-1:0] packMsg();
        logic [MSG-1:0] m;
        m = '0;
        for (int i = 0; i < NCHUNK; i++) m[i*W +: W] = msgBytes[i];
        return m;
    endfunction

    task automatic chkIdleOut(input string tag, input logic sent);
        chk({tag, "_valid"}, oValid, 1'b0);
        chk({tag, "_data"}, oData, 8'h00);
        chk({tag, "_last"}, oLast, 1'b0);
        chk({tag, "_busy"}, oBusy, 1'b0);
        chk({tag, "_sent"}, oSent_done, sent);
    endtask

    // Called at a negedge with the DUT already in SEND. Stops at the
    // negedge following handshake number stopAt.
    task automatic stream(input string tag, input bit rnd, input int stopAt);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < stopAt && cyc < 2000) begin
            chk({tag, "_valid"}, oValid, 1'b1);
            chk({tag, "_data"}, oData, msgBytes[k]);
            chk({tag, "_last"}, oLast, (k == NCHUNK - 1));
            chk({tag, "_busy"}, oBusy, 1'b1);
            chk({tag, "_sent"}, oSent_done, 1'b0);
            if (rnd) begin
                iReady = 1'($urandom_range(0, 1));
                iEncrypt_done = (cyc != 5);
            end else begin
                iReady = 1'b1;
            end
            if (iReady) k++;
            @(negedge iClk);
            cyc++;
        end
        chk({tag, "_handshakes"}, k, stopAt);
        iEncrypt_done = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge iClk);
        @(negedge iClk);
        chkIdleOut("reset", 1'b0);
        chk("small_reset_valid", rValid, 1'b0);
        chk("small_reset_sent", rSent, 1'b0);
        iRst = 1'b1;
        @(negedge iClk);

        // Basic stream: chunk i = i
        for (int i = 0; i < NCHUNK; i++) msgBytes[i] = 8'(i);
        iCiphertext = packMsg();
        iEncrypt_done = 1'b1;
        iReady = 1'b1;
        chk("pre_edge_valid", oValid, 1'b0);
        @(negedge iClk);
        stream("basic", 1'b0, NCHUNK);
        chkIdleOut("basic_done", 1'b1);

        // Re-trigger after DONE is ignored
        iEncrypt_done = 1'b0;
        @(negedge iClk);
        iEncrypt_done = 1'b1;
        @(negedge iClk);
        @(negedge iClk);
        chkIdleOut("retrig_done", 1'b1);

        // Random message, backpressure, capture isolation, re-trigger in SEND
        #2 iRst = 1'b0;
        #1 chkIdleOut("async_rst1", 1'b0);
        for (int i = 0; i < NCHUNK; i++) msgBytes[i] = 8'($urandom);
        iCiphertext = packMsg();
        iReady = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iCiphertext = '1;
        stream("bp", 1'b1, NCHUNK);
        chkIdleOut("bp_done", 1'b1);

        // Reset after 10 handshakes, then fresh transfer from chunk 0
        #2 iRst = 1'b0;
        #1 chkIdleOut("async_rst2", 1'b0);
        for (int i = 0; i < NCHUNK; i++) msgBytes[i] = 8'($urandom);
        iCiphertext = packMsg();
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        stream("partial", 1'b0, 10);
        #2 iRst = 1'b0;
        #1 chkIdleOut("mid_rst", 1'b0);
        for (int i = 0; i < NCHUNK; i++) msgBytes[i] = 8'($urandom);
        iCiphertext = packMsg();
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        stream("fresh", 1'b1, NCHUNK);
        chkIdleOut("fresh_done", 1'b1);

        // Reduced 16/8 instance
        rCt = 16'hBEEF;
        rDone = 1'b1;
        rReady = 1'b1;
        @(negedge iClk);
        chk("small_v0", rValid, 1'b1);
        chk("small_d0", rData, 8'hEF);
        chk("small_l0", rLast, 1'b0);
        @(negedge iClk);
        chk("small_v1", rValid, 1'b1);
        chk("small_d1", rData, 8'hBE);
        chk("small_l1", rLast, 1'b1);
        @(negedge iClk);
        chk("small_sent", rSent, 1'b1);
        chk("small_vdone", rValid, 1'b0);
        chk("small_ddone", rData, 8'h00);
        chk("small_bdone", rBusy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
